// File: rtl/fx2_slave_fifo_responder_if.sv
// FX2 synchronous slave-FIFO bus: strobes, endpoint select, data and flags.
// The FPGA-side master uses the master modport; the FX2 model uses slave.
interface fx2_slave_fifo_responder_if;
  logic [1:0] FIFOADR;
  logic       SLOE;
  logic       SLRD;
  logic       SLWR;
  logic       PKTEND;
  logic [7:0] FDI;
  logic [7:0] FDO;
  logic       FDO_OE;
  logic       FLAGA;
  logic       FLAGB;
  logic       FLAGC;
  logic       FLAGD;

  modport master (
    output FIFOADR, SLOE, SLRD, SLWR, PKTEND, FDI,
    input  FDO, FDO_OE, FLAGA, FLAGB, FLAGC, FLAGD
  );

  modport slave (
    input  FIFOADR, SLOE, SLRD, SLWR, PKTEND, FDI,
    output FDO, FDO_OE, FLAGA, FLAGB, FLAGC, FLAGD
  );
endinterface

// File: rtl/fx2_slave_fifo_responder.sv
// FX2-side slave-FIFO model: EP2 (host -> master) with read-ahead FDO and
// EP6 (master -> host) with packet staging, auto-commit and PKTEND/ZLP handling.
module fx2_slave_fifo_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned PKT_SIZE = 512
) (
  input  logic                         IFCLK,
  input  logic                         RESET,
  fx2_slave_fifo_responder_if.slave    fx2,
  input  logic [7:0]                   host_out_data,
  input  logic                         host_out_valid,
  output logic                         host_out_ready,
  output logic [7:0]                   host_in_data,
  output logic                         host_in_valid,
  input  logic                         host_in_ready,
  output logic [7:0]                   zlp_count,
  output logic                         overflow,
  output logic                         underrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] PktC   = CW'(PKT_SIZE);

  logic [7:0] ep2_mem [DEPTH];
  logic [7:0] ep6_mem [DEPTH];

  logic [AW-1:0] ep2_wr_q, ep2_rd_q, ep2_wr_d, ep2_rd_d;
  logic [CW-1:0] ep2_cnt_q, ep2_cnt_d;
  logic [7:0]    fdo_q, fdo_d;
  logic          flag_a_q, ready_q;

  logic [AW-1:0] ep6_wr_q, ep6_rd_q, ep6_wr_d, ep6_rd_d;
  logic [CW-1:0] committed_q, committed_d, staged_q, staged_d, staged_w;
  logic          flag_c_q, valid_q;
  logic [7:0]    zlp_q;
  logic          overflow_q, underrun_q;

  logic sel_ep2, sel_ep6;
  logic ep2_push, ep2_pop, ep2_bypass, ep2_rd_empty;
  logic ep6_wr, ep6_wr_full, ep6_pktend, ep6_pop, ep6_commit, ep6_zlp;

  always_comb begin
    sel_ep2      = (fx2.FIFOADR == 2'b00);
    sel_ep6      = (fx2.FIFOADR == 2'b10);

    ep2_push     = host_out_valid & ready_q;
    ep2_pop      = ~fx2.SLRD & sel_ep2 & ~flag_a_q;
    ep2_rd_empty = ~fx2.SLRD & sel_ep2 & flag_a_q;
    ep2_cnt_d    = ep2_cnt_q + CW'(ep2_push) - CW'(ep2_pop);
    ep2_wr_d     = ep2_wr_q + AW'(ep2_push);
    ep2_rd_d     = ep2_rd_q + AW'(ep2_pop);
    // The new head is the byte being pushed only if nothing else remains after the pop.
    ep2_bypass   = ep2_push & (ep2_cnt_q == CW'(ep2_pop));
    fdo_d        = ep2_bypass ? host_out_data : ep2_mem[ep2_rd_d];

    ep6_wr       = ~fx2.SLWR & sel_ep6 & ~flag_c_q;
    ep6_wr_full  = ~fx2.SLWR & sel_ep6 & flag_c_q;
    ep6_pktend   = ~fx2.PKTEND & sel_ep6;
    ep6_pop      = valid_q & host_in_ready;
    staged_w     = staged_q + CW'(ep6_wr);
    ep6_commit   = (ep6_pktend | (staged_w == PktC)) & (staged_w != '0);
    ep6_zlp      = ep6_pktend & (staged_w == '0);
    staged_d     = ep6_commit ? '0 : staged_w;
    committed_d  = committed_q - CW'(ep6_pop) + (ep6_commit ? staged_w : '0);
    ep6_wr_d     = ep6_wr_q + AW'(ep6_wr);
    ep6_rd_d     = ep6_rd_q + AW'(ep6_pop);
  end

  always_ff @(posedge IFCLK) begin
    if (ep2_push) ep2_mem[ep2_wr_q] <= host_out_data;
    if (ep6_wr)   ep6_mem[ep6_wr_q] <= fx2.FDI;
  end

  always_ff @(posedge IFCLK or negedge RESET) begin
    if (!RESET) begin
      ep2_wr_q    <= '0;
      ep2_rd_q    <= '0;
      ep2_cnt_q   <= '0;
      fdo_q       <= '0;
      flag_a_q    <= 1'b1;
      ready_q     <= 1'b1;
      ep6_wr_q    <= '0;
      ep6_rd_q    <= '0;
      committed_q <= '0;
      staged_q    <= '0;
      flag_c_q    <= 1'b0;
      valid_q     <= 1'b0;
      zlp_q       <= '0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      ep2_wr_q    <= ep2_wr_d;
      ep2_rd_q    <= ep2_rd_d;
      ep2_cnt_q   <= ep2_cnt_d;
      fdo_q       <= fdo_d;
      flag_a_q    <= (ep2_cnt_d == '0);
      ready_q     <= (ep2_cnt_d != DepthC);
      ep6_wr_q    <= ep6_wr_d;
      ep6_rd_q    <= ep6_rd_d;
      committed_q <= committed_d;
      staged_q    <= staged_d;
      flag_c_q    <= ((committed_d + staged_d) == DepthC);
      valid_q     <= (committed_d != '0);
      if (ep6_zlp)      zlp_q      <= zlp_q + 8'd1;
      if (ep6_wr_full)  overflow_q <= 1'b1;
      if (ep2_rd_empty) underrun_q <= 1'b1;
    end
  end

  assign fx2.FDO        = fdo_q;
  assign fx2.FDO_OE     = ~fx2.SLOE & sel_ep2;
  assign fx2.FLAGA      = flag_a_q;
  assign fx2.FLAGB      = 1'b0;
  assign fx2.FLAGC      = flag_c_q;
  assign fx2.FLAGD      = 1'b0;
  assign host_out_ready = ready_q;
  assign host_in_data   = ep6_mem[ep6_rd_q];
  assign host_in_valid  = valid_q;
  assign zlp_count      = zlp_q;
  assign overflow       = overflow_q;
  assign underrun       = underrun_q;

endmodule
